data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - CPU data-memory to asynchronous SRAM controller with programmable wait states
module data_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_req_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o,
  output logic [17:0] sram_addr_o,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe_o,
  input  logic [31:0] sram_data_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        data_oe_q, data_oe_d;
  logic        stall;

  // Only the 1 MiB word window reaches the SRAM; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:20], addr_i[1:0]};

  // Next-state logic: latch the request in IDLE, hold strobes for the wait count, release in DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    be_n_d    = be_n_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_oe_d = data_oe_q;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        stall = ce_i;
        if (ce_i) begin
          state_d   = ACCESS;
          cnt_d     = WAIT_LD;
          we_d      = we_i;
          be_n_d    = ~sel_i;
          addr_d    = addr_i[19:2];
          wdata_d   = data_i;
          ce_n_d    = 1'b0;
          oe_n_d    = we_i;
          we_n_d    = ~we_i;
          data_oe_d = we_i;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = DONE;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          be_n_d    = 4'hF;
          data_oe_d = 1'b0;
          if (!we_q) begin
            rdata_d = sram_data_i;
          end
        end
      end
      DONE: begin
        // The CPU advances on this edge, so any request seen now belongs to the next access.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered SRAM interface; reset parks the bus with every strobe inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      rdata_q   <= 32'd0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      be_n_q    <= 4'hF;
      addr_q    <= 18'd0;
      wdata_q   <= 32'd0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      be_n_q    <= be_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign stall_req_o    = stall & ~rst;
  assign data_o         = rdata_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign sram_be_n_o    = be_n_q;
  assign sram_addr_o    = addr_q;
  assign sram_data_o    = wdata_q;
  assign sram_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        ce_i, ce0_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;

  logic [31:0] data_o;
  logic        stall_req_o;
  logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_data_oe_o;
  logic [3:0]  sram_be_n_o;
  logic [17:0] sram_addr_o;
  logic [31:0] sram_data_o;
  logic [31:0] sram_data_i;

  logic [31:0] data0_o;
  logic        stall0;
  logic        ce_n0, oe_n0, we_n0, data_oe0;
  logic [3:0]  be_n0;
  logic [17:0] addr0;
  logic [31:0] sdata0;
  logic [31:0] sram0_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  logic [31:0] exp_q [$];

  data_mem_ctrl #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .stall_req_o(stall_req_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o), .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_data_oe_o(sram_data_oe_o), .sram_data_i(sram_data_i)
  );

  data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce0_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data0_o), .stall_req_o(stall0),
    .sram_ce_n_o(ce_n0), .sram_oe_n_o(oe_n0), .sram_we_n_o(we_n0),
    .sram_be_n_o(be_n0), .sram_addr_o(addr0), .sram_data_o(sdata0),
    .sram_data_oe_o(data_oe0), .sram_data_i(sram0_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple SRAM model behind the WAIT_CYCLES=2 instance.
  assign sram_data_i = mem[sram_addr_o[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'd0;
      mem[4]   <= 32'hDEADBEEF;
      mem[255] <= 32'h12345678;
    end else if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_addr;
    logic [3:0]  exp_be_n;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    logic [31:0] exp_d;

    vecs[0] = '{1'b0, 4'b1111, 32'h0000_0010, 32'h0,          18'h00004, 4'b0000, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'b0010, 32'h0000_0105, 32'h0000_AB00,  18'h00041, 4'b1101, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 4'b0000, 32'h000F_FFFC, 32'h0,          18'h3FFFF, 4'b1111, 32'h12345678};
    vecs[3] = '{1'b1, 4'b1111, 32'hFFF0_0020, 32'h1122_3344,  18'h00008, 4'b0000, 32'h12345678};
    vecs[4] = '{1'b0, 4'b1111, 32'h0000_0020, 32'h0,          18'h00008, 4'b0000, 32'h11223344};
    vecs[5] = '{1'b0, 4'b1111, 32'h0000_0104, 32'h0,          18'h00041, 4'b0000, 32'h0000AB00};

    rst = 1'b1; ce_i = 1'b1; ce0_i = 1'b0; we_i = 1'b0; sel_i = 4'hF;
    addr_i = 32'h0; data_i = 32'h0; sram0_rdata = 32'hCAFEF00D;

    // Reset behaviour
    #1 chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    chk("rst_stall_held", {31'd0, stall_req_o}, 32'd0);
    chk("rst_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n_o}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n_o}, 32'd1);
    chk("rst_be_n", {28'd0, sram_be_n_o}, 32'hF);
    chk("rst_addr", {14'd0, sram_addr_o}, 32'd0);
    chk("rst_sdata", sram_data_o, 32'd0);
    chk("rst_data_oe", {31'd0, sram_data_oe_o}, 32'd0);
    chk("rst_data_o", data_o, 32'd0);
    rst = 1'b0; ce_i = 1'b0;
    @(negedge clk);

    // Table-driven requests, each separated by one IDLE cycle
    for (int i = 0; i < 6; i++) begin
      ce_i = 1'b1; we_i = vecs[i].we; sel_i = vecs[i].sel;
      addr_i = vecs[i].addr; data_i = vecs[i].wdata;
      exp_q.push_back(vecs[i].exp_dout);
      #1;
      chk($sformatf("v%0d_idle_stall", i), {31'd0, stall_req_o}, 32'd1);
      chk($sformatf("v%0d_idle_ce_n", i), {31'd0, sram_ce_n_o}, 32'd1);
      n = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (sram_ce_n_o) break;
        n++;
        chk($sformatf("v%0d_a%0d_stall", i, n), {31'd0, stall_req_o}, 32'd1);
        chk($sformatf("v%0d_a%0d_addr", i, n), {14'd0, sram_addr_o}, {14'd0, vecs[i].exp_addr});
        chk($sformatf("v%0d_a%0d_be_n", i, n), {28'd0, sram_be_n_o}, {28'd0, vecs[i].exp_be_n});
        chk($sformatf("v%0d_a%0d_oe_n", i, n), {31'd0, sram_oe_n_o}, {31'd0, vecs[i].we});
        chk($sformatf("v%0d_a%0d_we_n", i, n), {31'd0, sram_we_n_o}, {31'd0, ~vecs[i].we});
        chk($sformatf("v%0d_a%0d_data_oe", i, n), {31'd0, sram_data_oe_o}, {31'd0, vecs[i].we});
        if (vecs[i].we) chk($sformatf("v%0d_a%0d_sdata", i, n), sram_data_o, vecs[i].wdata);
        if (n == 1) begin
          we_i = ~we_i; sel_i = ~sel_i; addr_i = ~addr_i; data_i = ~data_i;
        end
      end
      chk($sformatf("v%0d_access_len", i), n, 32'd3);
      chk($sformatf("v%0d_done_stall", i), {31'd0, stall_req_o}, 32'd0);
      chk($sformatf("v%0d_done_oe_n", i), {31'd0, sram_oe_n_o}, 32'd1);
      chk($sformatf("v%0d_done_we_n", i), {31'd0, sram_we_n_o}, 32'd1);
      chk($sformatf("v%0d_done_data_oe", i), {31'd0, sram_data_oe_o}, 32'd0);
      exp_d = exp_q.pop_front();
      chk($sformatf("v%0d_data_o", i), data_o, exp_d);
      ce_i = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_gap_stall", i), {31'd0, stall_req_o}, 32'd0);
      chk($sformatf("v%0d_gap_ce_n", i), {31'd0, sram_ce_n_o}, 32'd1);
      chk($sformatf("v%0d_hold_data_o", i), data_o, exp_d);
    end

    // Zero wait states: one ACCESS cycle, two stall cycles
    we_i = 1'b0; sel_i = 4'hF; addr_i = 32'h0000_0040; ce0_i = 1'b1;
    #1 chk("w0_idle_stall", {31'd0, stall0}, 32'd1);
    @(negedge clk);
    chk("w0_acc_ce_n", {31'd0, ce_n0}, 32'd0);
    chk("w0_acc_oe_n", {31'd0, oe_n0}, 32'd0);
    chk("w0_acc_stall", {31'd0, stall0}, 32'd1);
    chk("w0_acc_addr", {14'd0, addr0}, 32'h10);
    @(negedge clk);
    chk("w0_done_ce_n", {31'd0, ce_n0}, 32'd1);
    chk("w0_done_stall", {31'd0, stall0}, 32'd0);
    chk("w0_done_data_o", data0_o, 32'hCAFEF00D);
    ce0_i = 1'b0;
    @(negedge clk);
    chk("w0_idle_after", {31'd0, stall0}, 32'd0);

    // Reset in the second ACCESS cycle of a read
    ce_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; addr_i = 32'h0000_0010;
    @(negedge clk);
    chk("ra_a1_ce_n", {31'd0, sram_ce_n_o}, 32'd0);
    @(negedge clk);
    chk("ra_a2_ce_n", {31'd0, sram_ce_n_o}, 32'd0);
    rst = 1'b1;
    #1 chk("ra_rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk);
    chk("ra_ce_n", {31'd0, sram_ce_n_o}, 32'd1);
    chk("ra_oe_n", {31'd0, sram_oe_n_o}, 32'd1);
    chk("ra_be_n", {28'd0, sram_be_n_o}, 32'hF);
    chk("ra_stall", {31'd0, stall_req_o}, 32'd0);
    chk("ra_data_o", data_o, 32'd0);
    rst = 1'b0; ce_i = 1'b0;
    @(negedge clk);
    chk("ra_idle_stall", {31'd0, stall_req_o}, 32'd0);
    chk("ra_idle_data_o", data_o, 32'd0);
    ce_i = 1'b1;
    #1 chk("ra_idle_restart", {31'd0, stall_req_o}, 32'd1);
    @(negedge clk);
    chk("ra_restart_ce_n", {31'd0, sram_ce_n_o}, 32'd0);
    ce_i = 1'b0;
    n = 0;
    while (!sram_ce_n_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ra_restart_done", {31'd0, sram_ce_n_o}, 32'd1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
